hwpe_cfg_target: RTL

HWPE_CFG_TARGET -- requirements
Module: hwpe_cfg_target

---
 rtl/hwpe_cfg_target.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hwpe_cfg_target.sv
// Peripheral-bus configuration target for a hardware processing engine:
// register file, acquire/trigger/done job FSM and per-core end-of-job events.
module hwpe_cfg_target #(
  parameter int ID_WIDTH = 8,
  parameter int N_CORES  = 8,
  parameter int N_REGS   = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           periph_req_i,
  output logic                           periph_gnt_o,
  input  logic [31:0]                    periph_add_i,
  input  logic                           periph_wen_i,
  input  logic [3:0]                     periph_be_i,
  input  logic [31:0]                    periph_data_i,
  input  logic [ID_WIDTH-1:0]            periph_id_i,
  output logic [31:0]                    periph_r_data_o,
  output logic                           periph_r_valid_o,
  output logic [ID_WIDTH-1:0]            periph_r_id_o,
  output logic                           start_o,
  input  logic                           done_i,
  output logic                           busy_o,
  output logic [N_CORES-1:0][1:0]        evt_o,
  output logic [N_REGS-1:0][31:0]        regs_o,
  output logic [1:0]                     dbg_state
);

  // Handshake: every cycle with periph_req_i high is granted in that same
  // cycle; exactly one response (r_valid high for one cycle) follows on the
  // next cycle, carrying the captured ID. No back-pressure exists.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACQUIRED = 2'd1,
    RUNNING  = 2'd2
  } state_e;

  localparam logic [5:0] W_TRIGGER = 6'd0;
  localparam logic [5:0] W_ACQUIRE = 6'd1;
  localparam logic [5:0] W_STATUS  = 6'd3;
  localparam logic [5:0] W_JOB_ID  = 6'd4;
  localparam logic [5:0] W_CLEAR   = 6'd5;
  localparam logic [4:0] NR        = 5'(N_REGS);

  state_e                   state;
  logic [7:0]               job_cnt;
  logic [N_REGS-1:0][31:0]  job_regs;
  logic                     evt_pulse;

  logic [5:0]  word;
  logic        is_rd, is_wr;
  logic        hit_trigger, hit_acquire, hit_clear;
  logic        reg_hit, reg_wr;
  logic [31:0] rd_data;
  logic        unused_add;

  assign word        = periph_add_i[7:2];
  assign unused_add  = ^{periph_add_i[31:8], periph_add_i[1:0]};
  assign is_rd       = periph_req_i & periph_wen_i;
  assign is_wr       = periph_req_i & ~periph_wen_i;
  assign hit_trigger = is_wr && (word == W_TRIGGER);
  assign hit_acquire = is_rd && (word == W_ACQUIRE);
  assign hit_clear   = is_wr && (word == W_CLEAR);
  assign reg_hit     = (word[5:4] == 2'b01) && ({1'b0, word[3:0]} < NR);
  assign reg_wr      = is_wr && reg_hit;

  assign periph_gnt_o = periph_req_i;
  assign busy_o       = (state == RUNNING);
  assign regs_o       = job_regs;
  assign dbg_state    = state;

  always_comb begin
    for (int c = 0; c < N_CORES; c++) begin
      evt_o[c] = {1'b0, evt_pulse};
    end
  end

  // Read data always reflects the state of the request cycle.
  always_comb begin
    rd_data = '0;
    case (word)
      W_ACQUIRE: rd_data = (state == IDLE) ? {24'b0, job_cnt} : 32'hFFFF_FFFF;
      W_STATUS:  rd_data = {30'b0, state == ACQUIRED, state == RUNNING};
      W_JOB_ID:  rd_data = {24'b0, job_cnt};
      default: begin
        for (int k = 0; k < N_REGS; k++) begin
          if (reg_hit && (word[3:0] == 4'(k))) rd_data = job_regs[k];
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state            <= IDLE;
      job_cnt          <= '0;
      job_regs         <= '0;
      evt_pulse        <= 1'b0;
      start_o          <= 1'b0;
      periph_r_valid_o <= 1'b0;
      periph_r_data_o  <= '0;
      periph_r_id_o    <= '0;
    end else begin
      periph_r_valid_o <= periph_req_i;
      periph_r_data_o  <= is_rd ? rd_data : 32'h0;
      if (periph_req_i) periph_r_id_o <= periph_id_i;
      start_o   <= 1'b0;
      evt_pulse <= 1'b0;

      // Soft clear overrides any same-cycle completion: no event, no count.
      if (hit_clear) begin
        state    <= IDLE;
        job_regs <= '0;
      end else begin
        case (state)
          IDLE: if (hit_acquire) state <= ACQUIRED;
          ACQUIRED: begin
            if (hit_trigger) begin
              state   <= RUNNING;
              start_o <= 1'b1;
            end
          end
          RUNNING: begin
            if (done_i) begin
              state     <= IDLE;
              job_cnt   <= job_cnt + 8'd1;
              evt_pulse <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase

        // Job registers are frozen while the engine consumes them.
        if (reg_wr && (state != RUNNING)) begin
          for (int k = 0; k < N_REGS; k++) begin
            for (int b = 0; b < 4; b++) begin
              if ((word[3:0] == 4'(k)) && periph_be_i[b]) begin
                job_regs[k][8*b +: 8] <= periph_data_i[8*b +: 8];
              end
            end
          end
        end
      end
    end
  end

endmodule
